// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RISC-V control sequencer: fetch/decode/execute/mem/writeback with
// memory-response timeout, sticky illegal trap and a retired-instruction counter.
module riscv_mc_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  instr_type,
   input  logic [6:0]  opcode,
   input  logic        branch_taken,
   output logic        imem_req,
   input  logic        imem_rvalid,
   output logic        instr_latch_en,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_rvalid,
   output logic        alu_en,
   output logic        rf_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        instr_retired,
   output logic [31:0] retire_cnt,
   output logic        illegal
);

   // state     | meaning
   // S_FETCH   | imem_req held, wait for imem_rvalid (timed)
   // S_DECODE  | legality check of instr_type / opcode
   // S_EXECUTE | alu_en; branches retire here
   // S_MEM     | dmem_req held, wait for dmem_rvalid (timed); stores retire here
   // S_WB      | rf_we + pc_we, retire
   // S_TRAP    | illegal, everything idle until reset
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
   } state_t;

   localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2,
                          T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;
   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_JALR = 7'b1100111;
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   state_t         state_q, state_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [1:0]     pc_sel_q, pc_sel_d, exec_sel;
   logic           store_q, store_d;
   logic [31:0]    retire_cnt_q;
   logic           type_ok, opcode_ok;

   assign type_ok   = (instr_type <= T_J);
   assign opcode_ok = opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                     7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                                     7'b1101111};

   always_comb begin
      exec_sel = 2'd0;
      if (instr_type == T_B)
         exec_sel = {1'b0, branch_taken};
      else if (instr_type == T_J || opcode == OP_JALR)
         exec_sel = 2'd2;
   end

   always_comb begin
      state_d        = state_q;
      tmo_d          = '0;
      pc_sel_d       = pc_sel_q;
      store_d        = store_q;
      imem_req       = 1'b0;
      instr_latch_en = 1'b0;
      dmem_req       = 1'b0;
      dmem_we        = 1'b0;
      alu_en         = 1'b0;
      rf_we          = 1'b0;
      pc_we          = 1'b0;
      instr_retired  = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_rvalid) begin
               instr_latch_en = 1'b1;
               state_d        = S_DECODE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_TRAP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_DECODE: begin
            state_d = (type_ok && opcode_ok) ? S_EXECUTE : S_TRAP;
         end
         S_EXECUTE: begin
            alu_en   = 1'b1;
            pc_sel_d = exec_sel;
            store_d  = (instr_type == T_S);
            if (opcode == OP_LOAD || instr_type == T_S) begin
               state_d = S_MEM;
            end else if (instr_type == T_B) begin
               pc_we         = 1'b1;
               instr_retired = 1'b1;
               state_d       = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = store_q;
            if (dmem_rvalid) begin
               if (store_q) begin
                  pc_we         = 1'b1;
                  instr_retired = 1'b1;
                  state_d       = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_TRAP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WB: begin
            rf_we         = 1'b1;
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
      // nothing may strobe while reset is held, even though state already reads FETCH
      if (!rst_n) begin
         imem_req       = 1'b0;
         instr_latch_en = 1'b0;
         dmem_req       = 1'b0;
         dmem_we        = 1'b0;
         alu_en         = 1'b0;
         rf_we          = 1'b0;
         pc_we          = 1'b0;
         instr_retired  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         tmo_q        <= '0;
         pc_sel_q     <= 2'd0;
         store_q      <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         pc_sel_q <= pc_sel_d;
         store_q  <= store_d;
         if (instr_retired)
            retire_cnt_q <= retire_cnt_q + 32'd1;
      end
   end

   // EXECUTE drives the fresh selection; later states replay the captured one
   assign pc_sel     = (state_q == S_EXECUTE) ? exec_sel : pc_sel_q;
   assign retire_cnt = retire_cnt_q;
   assign illegal    = (state_q == S_TRAP);

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Bench for riscv_mc_ctrl: directed corner cases plus random instruction mix,
// checked per cycle against an instruction-level model of the sequencer.
module tb_riscv_mc_ctrl;
   localparam int TO = 15;

   localparam logic [7:0] M_IREQ = 8'h80, M_LAT = 8'h40, M_DREQ = 8'h20, M_DWE = 8'h10,
                          M_ALU = 8'h08, M_RFWE = 8'h04, M_PCWE = 8'h02, M_RET = 8'h01;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  instr_type = 3'd0;
   logic [6:0]  opcode = 7'd0;
   logic        branch_taken = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic        imem_req, instr_latch_en, dmem_req, dmem_we, alu_en, rf_we, pc_we;
   logic        instr_retired, illegal;
   logic [1:0]  pc_sel;
   logic [31:0] retire_cnt;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_cnt = 32'd0;
   logic        trapped;

   logic [2:0]  tbl_t  [9] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5};
   logic [6:0]  tbl_op [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                               7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};

   riscv_mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .instr_type(instr_type), .opcode(opcode),
      .branch_taken(branch_taken), .imem_req(imem_req), .imem_rvalid(imem_rvalid),
      .instr_latch_en(instr_latch_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_rvalid(dmem_rvalid), .alu_en(alu_en), .rf_we(rf_we), .pc_we(pc_we),
      .pc_sel(pc_sel), .instr_retired(instr_retired), .retire_cnt(retire_cnt),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] strb();
      return {imem_req, instr_latch_en, dmem_req, dmem_we, alu_en, rf_we, pc_we, instr_retired};
   endfunction

   function automatic bit is_legal(input logic [2:0] t, input logic [6:0] op);
      return (t <= 3'd5) && (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                        7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                                        7'b1101111});
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called #1 after inputs change, before the next rising edge
   task automatic check_cycle(input string tag, input logic [7:0] exp_strb, input logic exp_ill);
      chk({tag, "_strb"}, {24'd0, strb()}, {24'd0, exp_strb});
      chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
      chk({tag, "_cnt"}, retire_cnt, exp_cnt);
      if (exp_strb & M_RET) exp_cnt = exp_cnt + 32'd1;
   endtask

   task automatic noise();
      imem_rvalid  = 1'($urandom);
      dmem_rvalid  = 1'($urandom);
      branch_taken = 1'($urandom);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      noise();
      @(posedge clk);
      #1;
      exp_cnt = 32'd0;
      check_cycle("rst", 8'h00, 1'b0);
      chk("rst_pcsel", {30'd0, pc_sel}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      imem_rvalid = 1'b0;
      dmem_rvalid = 1'b1;
      #1;
      check_cycle("post_rst", M_IREQ, 1'b0);
   endtask

   task automatic trap_hold(input int n);
      for (int i = 0; i < n; i++) begin
         noise();
         #1;
         check_cycle("trap", 8'h00, 1'b1);
         @(negedge clk);
      end
   endtask

   // Walks one instruction through the model; fd/md = cycles before rvalid,
   // abort_m >= 0 pulls reset in that MEM cycle.
   task automatic run_instr(input logic [2:0] t, input logic [6:0] op, input logic bt,
                            input int fd, input int md, input int abort_m, output logic trp);
      bit        legal, is_mem, is_st, is_br;
      logic [1:0] esel;
      legal  = is_legal(t, op);
      is_st  = (t == 3'd2);
      is_mem = (op == 7'b0000011) || is_st;
      is_br  = (t == 3'd3);
      esel   = is_br ? {1'b0, bt} : ((t == 3'd5 || op == 7'b1100111) ? 2'd2 : 2'd0);
      trp = 1'b0;
      instr_type = t;
      opcode = op;
      for (int k = 0; ; k++) begin
         imem_rvalid  = (k == fd);
         dmem_rvalid  = 1'($urandom);
         branch_taken = 1'($urandom);
         #1;
         check_cycle("fetch", (k == fd) ? (M_IREQ | M_LAT) : M_IREQ, 1'b0);
         @(negedge clk);
         if (k == fd) break;
         if (k == TO - 1) begin trp = 1'b1; return; end
      end
      noise();
      #1;
      check_cycle("decode", 8'h00, 1'b0);
      @(negedge clk);
      if (!legal) begin trp = 1'b1; return; end
      imem_rvalid  = 1'($urandom);
      dmem_rvalid  = 1'($urandom);
      branch_taken = bt;
      #1;
      check_cycle("exec", is_br ? (M_ALU | M_PCWE | M_RET) : M_ALU, 1'b0);
      chk("exec_pcsel", {30'd0, pc_sel}, {30'd0, esel});
      @(negedge clk);
      if (is_br) return;
      if (is_mem) begin
         for (int m = 0; ; m++) begin
            if (m == abort_m) begin do_reset(); return; end
            dmem_rvalid  = (m == md);
            imem_rvalid  = 1'($urandom);
            branch_taken = 1'($urandom);
            #1;
            check_cycle("mem", M_DREQ | (is_st ? M_DWE : 8'h00) |
                        ((is_st && m == md) ? (M_PCWE | M_RET) : 8'h00), 1'b0);
            chk("mem_pcsel", {30'd0, pc_sel}, {30'd0, esel});
            @(negedge clk);
            if (m == md) begin
               if (is_st) return;
               break;
            end
            if (m == TO - 1) begin trp = 1'b1; return; end
         end
      end
      noise();
      #1;
      check_cycle("wb", M_RFWE | M_PCWE | M_RET, 1'b0);
      chk("wb_pcsel", {30'd0, pc_sel}, {30'd0, esel});
      @(negedge clk);
   endtask

   task automatic run_and_recover(input logic [2:0] t, input logic [6:0] op, input logic bt,
                                  input int fd, input int md, input int hold);
      run_instr(t, op, bt, fd, md, -1, trapped);
      if (trapped) begin
         trap_hold(hold);
         do_reset();
      end
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      // R-type with rvalid after 2 cycles
      run_and_recover(3'd0, 7'b0110011, 1'b0, 2, 0, 3);
      chk("r_retire", retire_cnt, 32'd1);
      run_and_recover(3'd1, 7'b0000011, 1'b0, 0, 3, 3);   // load
      run_and_recover(3'd2, 7'b0100011, 1'b0, 1, 3, 3);   // store
      run_and_recover(3'd3, 7'b1100011, 1'b1, 0, 0, 3);   // branch taken
      run_and_recover(3'd3, 7'b1100011, 1'b0, 0, 0, 3);   // branch not taken
      run_and_recover(3'd5, 7'b1101111, 1'b0, 0, 0, 3);   // JAL
      run_and_recover(3'd1, 7'b1100111, 1'b1, 0, 0, 3);   // JALR
      // fetch response exactly on the last allowed cycle, then one too late
      run_and_recover(3'd0, 7'b0110011, 1'b0, TO - 1, 0, 3);
      run_and_recover(3'd0, 7'b0110011, 1'b0, TO, 0, 20);
      // same boundary on the data side
      run_and_recover(3'd1, 7'b0000011, 1'b0, 0, TO - 1, 3);
      run_and_recover(3'd2, 7'b0100011, 1'b0, 0, TO + 2, 5);
      // illegal decode: unknown type, then bad opcode
      run_and_recover(3'd7, 7'b0110011, 1'b0, 0, 0, 20);
      run_and_recover(3'd0, 7'b0000000, 1'b0, 1, 0, 20);
      // reset in the middle of a pending load
      run_instr(3'd1, 7'b0000011, 1'b0, 0, 5, 2, trapped);
      run_and_recover(3'd0, 7'b0110011, 1'b0, 1, 0, 3);
      // counter wrap
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      exp_cnt = 32'hFFFF_FFFF;
      run_and_recover(3'd4, 7'b0110111, 1'b0, 0, 0, 3);
      chk("wrap", retire_cnt, 32'd0);
      // random mix
      for (int n = 0; n < 150; n++) begin
         int idx, fd, md;
         logic [2:0] t;
         logic [6:0] op;
         idx = $urandom_range(0, 10);
         if (idx < 9) begin
            t  = tbl_t[idx];
            op = tbl_op[idx];
         end else if (idx == 9) begin
            t  = 3'($urandom_range(6, 7));
            op = tbl_op[$urandom_range(0, 8)];
         end else begin
            t  = 3'($urandom_range(0, 5));
            op = 7'd0;
         end
         fd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 3);
         md = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 4);
         run_and_recover(t, op, 1'($urandom), fd, md, 3);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/riscv_mc_ctrl.md
RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max cycles to wait for any memory response before trapping.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 instr_type  input  3  decoded type of the latched instruction (riscv_pkg instr_type_enum: R/I/S/B/U/J, any other encoding = unknown).
REQ-005 opcode  input  7  opcode field of the latched instruction.
REQ-006 branch_taken  input  1  branch comparison result, sampled in EXECUTE.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_rvalid  input  1  instruction data valid.
REQ-009 instr_latch_en  output  1  capture enable for instruction register.
REQ-010 dmem_req / dmem_we  output  1 / 1  data memory request / write qualifier.
REQ-011 dmem_rvalid  input  1  data access complete.
REQ-012 alu_en, rf_we, pc_we  output  1 each  datapath strobes.
REQ-013 pc_sel  output  2  0 = pc+4, 1 = branch target, 2 = jump target; 3 unused.
REQ-014 instr_retired  output  1  one-cycle pulse per completed instruction.
REQ-015 retire_cnt  output  32  retired instruction count.
REQ-016 illegal  output  1  sticky trap flag.

Function
REQ-017 States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP; one-hot or binary encoding is an implementation choice.
REQ-018 FETCH: imem_req=1 held until imem_rvalid; on imem_rvalid, instr_latch_en=1 in the same cycle and next state = DECODE.
REQ-019 DECODE (1 cycle): unknown instr_type -> TRAP; opcode not in {0110011,0010011,0000011,1100111,0100011,1100011,0110111,0010111,1101111} -> TRAP; else -> EXECUTE.
REQ-020 EXECUTE (1 cycle): alu_en=1; load (0000011) or S-type -> MEM; B-type -> pc_we=1, instr_retired=1, next FETCH; all others -> WRITEBACK.
REQ-021 B-type pc_sel = 1 if branch_taken else 0; J-type and JALR (1100111) pc_sel = 2; all other instructions pc_sel = 0.
REQ-022 MEM: dmem_req=1 held until dmem_rvalid; dmem_we=1 only for S-type; on dmem_rvalid: load -> WRITEBACK, store -> pc_we=1, instr_retired=1, next FETCH.
REQ-023 WRITEBACK (1 cycle): rf_we=1, pc_we=1, instr_retired=1, next FETCH.
REQ-024 pc_sel shall be held valid from EXECUTE until the cycle pc_we is asserted.
REQ-025 Timeout counter counts cycles in FETCH or MEM without rvalid, cleared on state entry; reaching MEM_TIMEOUT without response -> TRAP; rvalid in the same cycle as the limit wins (no trap).
REQ-026 imem_rvalid outside FETCH and dmem_rvalid outside MEM are ignored.
REQ-027 TRAP: illegal=1, all strobes and requests 0, remains until reset.
REQ-028 retire_cnt increments by 1 on every instr_retired, wraps 0xFFFFFFFF -> 0.
REQ-029 All strobes (imem_req, instr_latch_en, dmem_req, dmem_we, alu_en, rf_we, pc_we, instr_retired) are Moore/state-qualified and never asserted in two different states simultaneously.

Reset
REQ-030 While rst_n=0 at a clock edge: state = FETCH, timeout counter = 0, retire_cnt = 0, illegal = 0, pc_sel = 0, all strobes 0.
REQ-031 First cycle after rst_n=1: imem_req=1.
REQ-032 Reset asserted mid-instruction (any state, including TRAP or pending MEM) aborts it without retire; pending memory responses arriving after reset are ignored per REQ-026 unless in FETCH.

Verification
REQ-033 R-type (0110011), rvalid after 2 cycles -> states FETCH,FETCH,FETCH,DECODE,EXECUTE,WRITEBACK; rf_we+pc_we in WRITEBACK, retire_cnt=1.
REQ-034 Load (0000011), dmem_rvalid after 3 cycles -> dmem_we=0, WRITEBACK entered, rf_we=1; store (S, 0100011) -> dmem_we=1, no rf_we, retire at dmem_rvalid.
REQ-035 B-type with branch_taken=1 -> pc_sel=1, pc_we=1 in EXECUTE, no rf_we; with branch_taken=0 -> pc_sel=0; JAL -> pc_sel=2 and rf_we=1.
REQ-036 instr_type unknown or opcode 0000000 -> TRAP after DECODE, illegal=1 sticky for 20 cycles, no requests; rst_n=0 one cycle -> illegal=0, imem_req=1.
REQ-037 MEM_TIMEOUT=15, no imem_rvalid -> TRAP after 15 FETCH cycles; rvalid exactly on cycle 15 -> DECODE, no trap.
REQ-038 Preset retire_cnt to 0xFFFFFFFF via 2^32-1 retires (or force) then one retire -> retire_cnt=0.
